// File: rtl/ebike_pkg.sv
// Shared widths, timer sizes and helpers for the e-bike sensor-conditioning path.
package ebike_pkg;
    localparam int CURR_W      = 12;
    localparam int ERR_W       = 13;
    localparam int CAD_CNT_W   = 5;
    localparam int WIN_W_FAST  = 16;
    localparam int WIN_W_FULL  = 24;
    localparam int SAMP_W_FAST = 8;
    localparam int SAMP_W_FULL = 14;
    localparam int CURR_ACC_W  = CURR_W + 2;
    localparam int TORQ_ACC_W  = CURR_W + 5;
    localparam int PROD_W      = 20;

    localparam logic [CURR_W-1:0] LOW_TORQUE_DEF = 12'h2A0;

    typedef logic [CAD_CNT_W-1:0] cad_cnt_t;

    localparam cad_cnt_t CAD_SAT       = '1;
    localparam cad_cnt_t CAD_MIN_PEDAL = 5'd2;

    // Anything that spills above bit 17 pins the target at full scale.
    function automatic logic [CURR_W-1:0] sat_target(input logic [PROD_W-1:0] prod);
        return (|prod[PROD_W-1:PROD_W-2]) ? {CURR_W{1'b1}}
                                          : prod[PROD_W-3:PROD_W-2-CURR_W];
    endfunction
endpackage

// File: rtl/cadence_meas.sv
// Crank-sensor synchroniser, rising-edge detect and per-window edge counter.
module cadence_meas
    import ebike_pkg::*;
#(
    parameter int WIN_W = WIN_W_FAST
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     cadence_raw,
    output logic     cad_rise,
    output cad_cnt_t cadence_cnt,
    output logic     not_pedaling
);
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             edge_q, edge_d;
    logic [WIN_W-1:0] win_q, win_d;
    cad_cnt_t         edge_cnt_q, edge_cnt_d;
    cad_cnt_t         cad_cnt_q, cad_cnt_d;
    logic             np_q, np_d;
    cad_cnt_t         cnt_inc;
    logic             rise;

    always_comb begin
        sync1_d    = cadence_raw;
        sync2_d    = sync1_q;
        edge_d     = sync2_q;
        rise       = sync2_q & ~edge_q;
        win_d      = win_q + WIN_W'(1);
        cnt_inc    = (rise && (edge_cnt_q != CAD_SAT)) ? edge_cnt_q + cad_cnt_t'(1) : edge_cnt_q;
        edge_cnt_d = cnt_inc;
        cad_cnt_d  = cad_cnt_q;
        np_d       = np_q;
        // An edge landing on the closing cycle still belongs to the old window.
        if (&win_q) begin
            cad_cnt_d  = cnt_inc;
            edge_cnt_d = '0;
            np_d       = (cnt_inc < CAD_MIN_PEDAL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            edge_q     <= 1'b0;
            win_q      <= '0;
            edge_cnt_q <= '0;
            cad_cnt_q  <= '0;
            np_q       <= 1'b1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            edge_q     <= edge_d;
            win_q      <= win_d;
            edge_cnt_q <= edge_cnt_d;
            cad_cnt_q  <= cad_cnt_d;
            np_q       <= np_d;
        end
    end

    assign cad_rise     = rise;
    assign cadence_cnt  = cad_cnt_q;
    assign not_pedaling = np_q;
endmodule

// File: rtl/cadence_torque_cond.sv
// Cadence/torque/current conditioning ahead of the assist PID: averages the
// sensors, forms the assist target and the signed current error.
module cadence_torque_cond
    import ebike_pkg::*;
#(
    parameter bit                FAST_SIM   = 1'b0,
    parameter logic [CURR_W-1:0] LOW_TORQUE = LOW_TORQUE_DEF,
    parameter int                WIN_W      = FAST_SIM ? WIN_W_FAST : WIN_W_FULL,
    parameter int                SAMP_W     = FAST_SIM ? SAMP_W_FAST : SAMP_W_FULL
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cadence_raw,
    input  logic [CURR_W-1:0]       curr,
    input  logic [CURR_W-1:0]       torque,
    input  logic [2:0]              scale,
    output logic signed [ERR_W-1:0] error,
    output logic                    not_pedaling,
    output logic [CURR_W-1:0]       target_curr,
    output logic [CURR_W-1:0]       avg_curr,
    output logic [CAD_CNT_W-1:0]    cadence_cnt
);
    logic                  cad_rise;
    cad_cnt_t              cad_cnt;
    logic                  np;
    logic [SAMP_W-1:0]     samp_q, samp_d;
    logic [CURR_ACC_W-1:0] curr_acc_q, curr_acc_d;
    logic [TORQ_ACC_W-1:0] torq_acc_q, torq_acc_d;
    logic                  np_dly_q, np_dly_d;
    logic [CURR_W-1:0]     target_q, target_d;
    logic [ERR_W-1:0]      error_q, error_d;
    logic [CURR_W-1:0]     avg_torque, avg_curr_w, torq_excess;
    logic [PROD_W-1:0]     prod;

    cadence_meas #(.WIN_W(WIN_W)) u_meas (
        .clk          (clk),
        .rst          (rst),
        .cadence_raw  (cadence_raw),
        .cad_rise     (cad_rise),
        .cadence_cnt  (cad_cnt),
        .not_pedaling (np)
    );

    assign avg_torque = torq_acc_q[TORQ_ACC_W-1:TORQ_ACC_W-CURR_W];
    assign avg_curr_w = curr_acc_q[CURR_ACC_W-1:CURR_ACC_W-CURR_W];

    always_comb begin
        samp_d     = samp_q + SAMP_W'(1);
        np_dly_d   = np;
        curr_acc_d = curr_acc_q;
        if (&samp_q) begin
            curr_acc_d = curr_acc_q - (curr_acc_q >> 2)
                       + {{(CURR_ACC_W-CURR_W){1'b0}}, curr};
        end

        // Restarting pedaling reloads the torque filter so assist does not ramp from stale data.
        torq_acc_d = torq_acc_q;
        if (np_dly_q && !np) begin
            torq_acc_d = {torque, {(TORQ_ACC_W-CURR_W){1'b0}}};
        end else if (cad_rise) begin
            torq_acc_d = torq_acc_q - (torq_acc_q >> 5)
                       + {{(TORQ_ACC_W-CURR_W){1'b0}}, torque};
        end

        torq_excess = avg_torque - LOW_TORQUE;
        prod = {{(PROD_W-CURR_W){1'b0}}, torq_excess}
             * {{(PROD_W-CAD_CNT_W){1'b0}}, cad_cnt}
             * {{(PROD_W-3){1'b0}}, scale};
        target_d = '0;
        if (!np && (avg_torque > LOW_TORQUE) && (scale != 3'd0)) begin
            target_d = sat_target(prod);
        end

        error_d = '0;
        if (!np) begin
            error_d = {1'b0, target_q} - {1'b0, avg_curr_w};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q     <= '0;
            curr_acc_q <= '0;
            torq_acc_q <= '0;
            np_dly_q   <= 1'b1;
            target_q   <= '0;
            error_q    <= '0;
        end else begin
            samp_q     <= samp_d;
            curr_acc_q <= curr_acc_d;
            torq_acc_q <= torq_acc_d;
            np_dly_q   <= np_dly_d;
            target_q   <= target_d;
            error_q    <= error_d;
        end
    end

    assign error        = $signed(error_q);
    assign not_pedaling = np;
    assign target_curr  = target_q;
    assign avg_curr     = avg_curr_w;
    assign cadence_cnt  = cad_cnt;
endmodule

// File: tb/tb_cadence_torque_cond.sv
// Directed + randomized bench for cadence_torque_cond with a cycle-counting reference model.
module tb_cadence_torque_cond;
    localparam int WIN_W = 11;
    localparam int WIN   = 1 << WIN_W;
    localparam int SAMP  = 256;
    localparam int LOW   = 672;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cadence_raw = 1'b0;
    logic [11:0] curr = '0;
    logic [11:0] torque = '0;
    logic [2:0]  scale = '0;
    logic [12:0] error;
    logic        not_pedaling;
    logic [11:0] target_curr;
    logic [11:0] avg_curr;
    logic [4:0]  cadence_cnt;

    int checks = 0;
    int errors = 0;

    int m_n, m_prev_raw, m_edge_cnt, m_cad, m_np, m_np_dly;
    int m_curr_acc, m_torq_acc, m_target, m_error;
    int due[$];

    always #5 clk = ~clk;

    cadence_torque_cond #(
        .FAST_SIM   (1'b1),
        .LOW_TORQUE (12'h2A0),
        .WIN_W      (WIN_W),
        .SAMP_W     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cadence_raw  (cadence_raw),
        .curr         (curr),
        .torque       (torque),
        .scale        (scale),
        .error        (error),
        .not_pedaling (not_pedaling),
        .target_curr  (target_curr),
        .avg_curr     (avg_curr),
        .cadence_cnt  (cadence_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, m_n);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_prev_raw = 0; m_edge_cnt = 0; m_cad = 0;
        m_np = 1; m_np_dly = 1; m_curr_acc = 0; m_torq_acc = 0;
        m_target = 0; m_error = 0;
        due.delete();
    endtask

    // One clock of the reference: every update uses the values from before the edge.
    task automatic model_step(input int r_raw, input int r_curr, input int r_torq, input int r_scale);
        int o_np, o_cad, o_target, o_curr, o_torq, cnt, avg_t, prod;
        bit rise;
        o_np = m_np; o_cad = m_cad; o_target = m_target;
        o_curr = m_curr_acc; o_torq = m_torq_acc;
        m_n++;
        rise = 1'b0;
        if (due.size() > 0 && due[0] == m_n) begin
            rise = 1'b1;
            void'(due.pop_front());
        end
        if (r_raw != 0 && m_prev_raw == 0) due.push_back(m_n + 2);
        m_prev_raw = r_raw;

        cnt = m_edge_cnt + ((rise && m_edge_cnt < 31) ? 1 : 0);
        if (m_n % WIN == 0) begin
            m_cad = cnt; m_edge_cnt = 0; m_np = (cnt < 2) ? 1 : 0;
        end else begin
            m_edge_cnt = cnt;
        end

        if (m_n % SAMP == 0) m_curr_acc = o_curr - o_curr / 4 + r_curr;

        if (m_np_dly != 0 && o_np == 0) m_torq_acc = r_torq * 32;
        else if (rise) m_torq_acc = o_torq - o_torq / 32 + r_torq;
        m_np_dly = o_np;

        avg_t = o_torq / 32;
        if (o_np != 0 || avg_t <= LOW || r_scale == 0) m_target = 0;
        else begin
            prod = (avg_t - LOW) * o_cad * r_scale;
            m_target = (prod >= (1 << 18)) ? 4095 : (prod / 64) % 4096;
        end

        m_error = (o_np != 0) ? 0 : ((o_target - o_curr / 4) & 'h1FFF);
    endtask

    task automatic check_all();
        chk("cadence_cnt", cadence_cnt, m_cad);
        chk("not_pedaling", not_pedaling, m_np);
        chk("target_curr", target_curr, m_target);
        chk("avg_curr", avg_curr, m_curr_acc / 4);
        chk("error", error, m_error);
    endtask

    task automatic step();
        logic r_rst, r_raw;
        logic [11:0] r_curr, r_torq;
        logic [2:0] r_scale;
        r_rst = rst; r_raw = cadence_raw; r_curr = curr; r_torq = torque; r_scale = scale;
        @(posedge clk);
        #1;
        if (r_rst) model_reset();
        else model_step(int'(r_raw), int'(r_curr), int'(r_torq), int'(r_scale));
        if (m_n % 8 == 0 || m_n % WIN < 4) check_all();
    endtask

    // Runs exactly one window; optionally adds an edge that lands on the closing cycle.
    task automatic run_window(input int npulse, input bit end_edge);
        int sp;
        while (m_n % WIN != 0) step();
        sp = (npulse > 0) ? (WIN - 100) / npulse : WIN;
        for (int k = 0; k < WIN; k++) begin
            logic hi;
            hi = 1'b0;
            if (npulse > 0 && k >= 20 && (k - 20) / sp < npulse && (k - 20) % sp < 3) hi = 1'b1;
            if (end_edge && k >= WIN - 3) hi = 1'b1;
            cadence_raw = hi;
            step();
        end
        cadence_raw = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_target"}, target_curr, 0);
        chk({tag, "_cad"}, cadence_cnt, 0);
        chk({tag, "_np"}, not_pedaling, 1);
    endtask

    initial begin
        model_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
        chk_reset_state("por");

        // Reset mid-window with edges in flight.
        torque = 12'h500; scale = 3'd2; curr = 12'h080;
        for (int k = 0; k < 1000; k++) begin
            cadence_raw = ((k % 100) < 3);
            step();
        end
        cadence_raw = 1'b1; step();
        rst = 1'b1; cadence_raw = 1'b0; step(); step(); rst = 1'b0;
        chk_reset_state("midrst");
        run_window(3, 1'b0);
        chk("first_win_cad", cadence_cnt, 3);
        chk("first_win_np", not_pedaling, 0);

        // Randomized windows.
        for (int w = 0; w < 3; w++) begin
            torque = 12'($urandom_range(0, 4095));
            curr   = 12'($urandom_range(0, 4095));
            scale  = 3'($urandom_range(0, 7));
            run_window(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
        end

        // Cadence counting, including an edge on the window-end cycle.
        curr = '0; torque = 12'h400; scale = 3'd3;
        run_window(8, 1'b0);
        chk("cad8", cadence_cnt, 8);
        chk("cad8_np", not_pedaling, 0);
        run_window(8, 1'b1);
        chk("cad_end_edge", cadence_cnt, 9);

        // Stop pedaling, then resume with torque reseed.
        run_window(0, 1'b0);
        chk("stop_np", not_pedaling, 1);
        step();
        chk("stop_error", error, 0);
        run_window(8, 1'b0);
        chk("resume_cad", cadence_cnt, 8);
        step(); step(); step();
        chk("assist_target", target_curr, 12'h084);
        chk("assist_error", error, 13'h0084);

        // Current averaging step response.
        while (m_n % SAMP != 0) step();
        curr = 12'h100;
        repeat (SAMP) step();
        chk("avg_1st", avg_curr, 12'h040);
        repeat (SAMP) step();
        chk("avg_2nd", avg_curr, 12'h070);
        repeat (SAMP * 30) step();
        chk("avg_conv", avg_curr, 12'h100);

        // Saturation, then dead-band.
        curr = '0; torque = 12'hFFF; scale = 3'd7;
        repeat (SAMP * 40) step();
        chk("decayed_avg", avg_curr, 0);
        run_window(40, 1'b0);
        chk("sat_cad", cadence_cnt, 31);
        step(); step(); step();
        chk("sat_target", target_curr, 12'hFFF);
        chk("sat_error", error, 13'h0FFF);
        torque = 12'h2A0;
        run_window(0, 1'b0);
        run_window(40, 1'b0);
        step(); step(); step();
        chk("deadband_target", target_curr, 0);
        chk("deadband_error", error, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
